cpu_phase_decoder: RTL and testbench
====================================

Name: cpu_phase_decoder

Overview:
- Receive-side partner of the eight-phase CPU timing generator.
- Samples the eight one-hot phase strobes (phase 1 through phase 8, one strobe every STRIDE clk, period 8*STRIDE) and checks them for shape, order and spacing.
- Decodes them into a registered phase index, an accept pulse and a cycle-complete pulse for downstream CPU stages.
- Runs a lock FSM with sticky error reporting, so sequencer faults are visible to the CPU control and debug logic.

Parameters:
STRIDE, 2, clk cycles between consecutive strobes (must be >= 2)
CNT_W, 16, width of completed-cycle counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
phase_in  in  8  phase strobes; bit n-1 = phase n strobe
err_clr  in  1  synchronous clear of err_sticky/err_code
phase_idx  out  3  index (0..7) of last accepted strobe
phase_stb  out  1  one-clk pulse per accepted strobe
cycle_done  out  1  one-clk pulse when index 7 is accepted
locked  out  1  high while FSM in LOCKED
err_pulse  out  1  one-clk pulse per detected error
err_code  out  2  first error since clear: 0 multi-hot, 1 early, 2 order, 3 late
err_sticky  out  1  set on any error; held until err_clr
cycle_count  out  CNT_W  completed 8-phase cycles, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values:
  - All outputs 0.
  - FSM in HUNT.
  - Internal gap counter d = 0.
  - Internal expected index = 0.
- All outputs are registered. Each response appears 1 clk after the clk edge that sampled phase_in.
- Gap counter d:
  - Cleared to 0 on each accepted strobe.
  - Otherwise increments each clk, saturating at STRIDE.
  - Ignored in HUNT.
- FSM states: HUNT, TRACK, LOCKED.
  - HUNT: only phase_in == 8'h01 exactly is accepted. Accept sets idx = 0, pulses phase_stb, moves to TRACK, expected = 1. All other values, including multi-hot, are ignored without error.
  - TRACK/LOCKED, per sampling edge, in priority order:
    1. more than one bit set -> multi-hot error
    2. single bit set with d < STRIDE-1 (earlier than STRIDE clks after last accept) -> early error
    3. single bit set at the correct spacing but bit index != expected -> order error
    4. phase_in == 0 with d == STRIDE-1 (the edge where a strobe is due) -> late error
    5. single bit == expected at the correct spacing -> accept
    6. zero before due -> idle
  - Accept: phase_idx <= index; phase_stb pulses; expected <= index+1 mod 8.
  - Accept of index 7 in TRACK or LOCKED:
    - pulses cycle_done together with phase_stb;
    - increments cycle_count;
    - TRACK moves to LOCKED; LOCKED stays LOCKED.
- Any error:
  - err_pulse for 1 clk; no phase_stb.
  - FSM -> HUNT; locked drops on the next clk.
  - phase_idx holds its last value.
  - The offending sample is not re-evaluated; HUNT starts on the following edge.
- err_code captures only the first error while err_sticky == 0. Later errors pulse err_pulse but leave err_code unchanged.
- err_clr clears err_sticky and err_code. An error on the same edge as err_clr wins: sticky stays 1 and err_code takes the new error's code.
- cycle_count is not cleared by errors, only by reset. It wraps to 0 after 2^CNT_W-1.
- Reset asserted mid-cycle returns everything to reset values immediately. After release, the first 8'h01 restarts the sequence.

Test Plan:
- Nominal, STRIDE=2:
  - Stimulus: release reset, drive 8'h01 at edge N, then 02, 04, 08, 10, 20, 40, 80 at N+2 … N+14, zero between.
  - Required: phase_stb at N+1, N+3 … N+15 with phase_idx 0..7; cycle_done and locked rise at N+15; cycle_count = 1.
  - Continue for 3 more cycles -> cycle_count = 4, locked stays 1, no err_pulse.
- Late:
  - Stimulus: while locked, omit the 8'h08 strobe.
  - Required: err_pulse and err_code = 3 one clk after the due edge; err_sticky = 1; locked = 0.
  - Next 8'h01 relocks after 8 strobes; err_sticky stays 1 until err_clr.
- Order and multi-hot:
  - Order: while locked, drive 8'h20 where 8'h08 is due -> err_code = 2.
  - Multi-hot: after err_clr, drive 8'h03 -> err_code = 0.
  - Multi-hot while in HUNT -> no err_pulse.
- Early:
  - Stimulus: drive the correct next strobe 1 clk after the last accept (d = 0).
  - Required: err_code = 1, FSM to HUNT.
  - Same edge as err_clr -> err_sticky remains 1.
- Reset mid-cycle:
  - Stimulus: assert reset between the 8'h04 and 8'h08 strobes.
  - Required: all outputs 0 immediately (asynchronous); after release, the stray 8'h08 is ignored and lock is reacquired from the next 8'h01.
- Wrap, CNT_W=4:
  - Stimulus: run 16 clean cycles.
  - Required: cycle_count returns to 0 on the 16th cycle_done.

Source files
------------

// File: rtl/cpu_phase_decoder.sv
// Receive-side decoder for the eight-phase CPU timing strobes: checks shape,
// order and spacing, and reports phase index, cycle completion and lock state.
module cpu_phase_decoder #(
    parameter int STRIDE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       phase_in,
    input  logic             err_clr,
    output logic [2:0]       phase_idx,
    output logic             phase_stb,
    output logic             cycle_done,
    output logic             locked,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int D_W = $clog2(STRIDE + 1);
    localparam logic [D_W-1:0] D_DUE = D_W'(STRIDE - 1);
    localparam logic [D_W-1:0] D_SAT = D_W'(STRIDE);

    localparam logic [1:0] ERR_MULTI = 2'd0;
    localparam logic [1:0] ERR_EARLY = 2'd1;
    localparam logic [1:0] ERR_ORDER = 2'd2;
    localparam logic [1:0] ERR_LATE  = 2'd3;

    // Position of the highest set bit; only meaningful for one-hot input.
    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            r = v[i] ? 3'(i) : r;
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [D_W-1:0]   d_q, d_d;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       idx_q, idx_d;
    logic             stb_q, stb_d;
    logic             done_q, done_d;
    logic             locked_q, locked_d;
    logic             perr_q, perr_d;
    logic [1:0]       code_q, code_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             multi_s;
    logic             single_s;
    logic [2:0]       in_idx_s;
    logic             err_s;
    logic [1:0]       err_code_s;
    logic [D_W-1:0]   d_inc_s;

    // Decode the sample and compute next state of the lock FSM and outputs.
    always_comb begin
        multi_s    = (phase_in & (phase_in - 8'd1)) != 8'd0;
        single_s   = (phase_in != 8'd0) && !multi_s;
        in_idx_s   = enc8(phase_in);
        d_inc_s    = (d_q == D_SAT) ? d_q : (d_q + D_W'(1));
        err_s      = 1'b0;
        err_code_s = ERR_MULTI;
        state_d    = state_q;
        d_d        = d_inc_s;
        exp_d      = exp_q;
        idx_d      = idx_q;
        stb_d      = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        code_d     = code_q;

        case (state_q)
            HUNT: begin
                if (phase_in == 8'h01) begin
                    idx_d   = 3'd0;
                    stb_d   = 1'b1;
                    exp_d   = 3'd1;
                    d_d     = {D_W{1'b0}};
                    state_d = TRACK;
                end else begin
                    state_d = HUNT;
                end
            end
            TRACK, LOCKED: begin
                if (multi_s) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_MULTI;
                end else if (single_s && (d_q < D_DUE)) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_EARLY;
                end else if (single_s && (in_idx_s != exp_q)) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_ORDER;
                end else if ((phase_in == 8'd0) && (d_q == D_DUE)) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_LATE;
                end else if (single_s) begin
                    idx_d = in_idx_s;
                    stb_d = 1'b1;
                    exp_d = in_idx_s + 3'd1;
                    d_d   = {D_W{1'b0}};
                    if (in_idx_s == 3'd7) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = LOCKED;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end

                if (err_s) begin
                    state_d = HUNT;
                    d_d     = {D_W{1'b0}};
                end else begin
                    state_d = state_d;
                end
            end
            default: begin
                state_d = HUNT;
                d_d     = {D_W{1'b0}};
            end
        endcase

        // A new error outranks a simultaneous clear.
        if (err_s) begin
            sticky_d = 1'b1;
            code_d   = (!sticky_q || err_clr) ? err_code_s : code_q;
        end else if (err_clr) begin
            sticky_d = 1'b0;
            code_d   = 2'd0;
        end else begin
            sticky_d = sticky_q;
            code_d   = code_q;
        end

        perr_d   = err_s;
        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            d_q      <= {D_W{1'b0}};
            exp_q    <= 3'd0;
            idx_q    <= 3'd0;
            stb_q    <= 1'b0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            perr_q   <= 1'b0;
            code_q   <= 2'd0;
            sticky_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
            stb_q    <= stb_d;
            done_q   <= done_d;
            locked_q <= locked_d;
            perr_q   <= perr_d;
            code_q   <= code_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign phase_idx   = idx_q;
    assign phase_stb   = stb_q;
    assign cycle_done  = done_q;
    assign locked      = locked_q;
    assign err_pulse   = perr_q;
    assign err_code    = code_q;
    assign err_sticky  = sticky_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_phase_decoder.sv
// Directed bench for cpu_phase_decoder: a CNT_W=16 instance for function and
// a CNT_W=4 instance sharing the same stimulus for counter wrap.
module tb_cpu_phase_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] phase_in = 8'h00;

    logic [2:0]  a_idx, b_idx;
    logic        a_stb, b_stb, a_done, b_done, a_lock, b_lock;
    logic        a_perr, b_perr, a_sticky, b_sticky;
    logic [1:0]  a_code, b_code;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_phase_decoder #(.STRIDE(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .phase_in(phase_in), .err_clr(err_clr),
        .phase_idx(a_idx), .phase_stb(a_stb), .cycle_done(a_done), .locked(a_lock),
        .err_pulse(a_perr), .err_code(a_code), .err_sticky(a_sticky), .cycle_count(a_cnt)
    );

    cpu_phase_decoder #(.STRIDE(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .phase_in(phase_in), .err_clr(err_clr),
        .phase_idx(b_idx), .phase_stb(b_stb), .cycle_done(b_done), .locked(b_lock),
        .err_pulse(b_perr), .err_code(b_code), .err_sticky(b_sticky), .cycle_count(b_cnt)
    );

    task automatic step(input logic [7:0] v);
        phase_in = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_cycle();
        for (int i = 0; i < 8; i++) begin
            step(8'h01 << i);
            step(8'h00);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if ({a_idx, a_stb, a_done, a_lock, a_perr, a_code, a_sticky} !== 10'd0) begin bad++; $display("FAIL reset_a_outs got=%b exp=0", {a_idx, a_stb, a_done, a_lock, a_perr, a_code, a_sticky}); end
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL reset_a_cnt got=%0d exp=0", a_cnt); end
        total++; if ({b_idx, b_stb, b_done, b_lock, b_perr, b_code, b_sticky, b_cnt} !== 14'd0) begin bad++; $display("FAIL reset_b_outs got=%b exp=0", {b_idx, b_stb, b_done, b_lock, b_perr, b_code, b_sticky, b_cnt}); end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        step(8'h00);
        for (int i = 0; i < 8; i++) begin
            step(8'h01 << i);
            total++; if (a_stb !== 1'b1 || a_idx !== 3'(i)) begin bad++; $display("FAIL nom_stb[%0d] got stb=%b idx=%0d exp stb=1 idx=%0d", i, a_stb, a_idx, i); end
            total++; if (a_done !== (i == 7) || a_lock !== (i == 7) || a_perr !== 1'b0) begin bad++; $display("FAIL nom_flags[%0d] got done=%b lock=%b perr=%b exp done=%b lock=%b perr=0", i, a_done, a_lock, a_perr, i == 7, i == 7); end
            step(8'h00);
            total++; if (a_stb !== 1'b0 || a_done !== 1'b0) begin bad++; $display("FAIL nom_gap[%0d] got stb=%b done=%b exp 0 0", i, a_stb, a_done); end
        end
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL nom_cnt1 got=%0d exp=1", a_cnt); end
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 8; i++) begin
                step(8'h01 << i);
                total++; if (a_perr !== 1'b0 || a_stb !== 1'b1) begin bad++; $display("FAIL nom_run[%0d.%0d] got perr=%b stb=%b exp 0 1", c, i, a_perr, a_stb); end
                step(8'h00);
            end
        end
        total++; if (a_cnt !== 16'd4 || a_lock !== 1'b1 || a_sticky !== 1'b0) begin bad++; $display("FAIL nom_cnt4 got cnt=%0d lock=%b sticky=%b exp 4 1 0", a_cnt, a_lock, a_sticky); end
    endtask

    task automatic test_late();
        step(8'h01); step(8'h00); step(8'h02); step(8'h00); step(8'h04); step(8'h00);
        step(8'h00);
        total++; if (a_perr !== 1'b1 || a_code !== 2'd3 || a_sticky !== 1'b1) begin bad++; $display("FAIL late_err got perr=%b code=%0d sticky=%b exp 1 3 1", a_perr, a_code, a_sticky); end
        total++; if (a_lock !== 1'b0 || a_stb !== 1'b0 || a_idx !== 3'd2) begin bad++; $display("FAIL late_state got lock=%b stb=%b idx=%0d exp 0 0 2", a_lock, a_stb, a_idx); end
        step(8'h00);
        total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL late_pulse_width got=%b exp=0", a_perr); end
        run_cycle();
        total++; if (a_lock !== 1'b1 || a_sticky !== 1'b1 || a_code !== 2'd3 || a_cnt !== 16'd5) begin bad++; $display("FAIL late_relock got lock=%b sticky=%b code=%0d cnt=%0d exp 1 1 3 5", a_lock, a_sticky, a_code, a_cnt); end
    endtask

    task automatic test_order();
        err_clr = 1'b1;
        step(8'h01);
        err_clr = 1'b0;
        total++; if (a_sticky !== 1'b0 || a_code !== 2'd0 || a_stb !== 1'b1 || a_lock !== 1'b1) begin bad++; $display("FAIL order_clr got sticky=%b code=%0d stb=%b lock=%b exp 0 0 1 1", a_sticky, a_code, a_stb, a_lock); end
        step(8'h00); step(8'h02); step(8'h00); step(8'h04); step(8'h00);
        step(8'h20);
        total++; if (a_perr !== 1'b1 || a_code !== 2'd2 || a_sticky !== 1'b1 || a_stb !== 1'b0) begin bad++; $display("FAIL order_err got perr=%b code=%0d sticky=%b stb=%b exp 1 2 1 0", a_perr, a_code, a_sticky, a_stb); end
        total++; if (a_lock !== 1'b0 || a_idx !== 3'd2) begin bad++; $display("FAIL order_state got lock=%b idx=%0d exp 0 2", a_lock, a_idx); end
        step(8'h00);
    endtask

    task automatic test_multi();
        step(8'h03);
        total++; if (a_perr !== 1'b0 || a_stb !== 1'b0) begin bad++; $display("FAIL multi_hunt got perr=%b stb=%b exp 0 0", a_perr, a_stb); end
        err_clr = 1'b1;
        step(8'h01);
        err_clr = 1'b0;
        step(8'h00);
        step(8'h03);
        total++; if (a_perr !== 1'b1 || a_code !== 2'd0 || a_sticky !== 1'b1) begin bad++; $display("FAIL multi_err got perr=%b code=%0d sticky=%b exp 1 0 1", a_perr, a_code, a_sticky); end
        step(8'h00);
        step(8'h01); step(8'h00); step(8'h00);
        total++; if (a_perr !== 1'b1 || a_code !== 2'd0) begin bad++; $display("FAIL first_err_kept got perr=%b code=%0d exp 1 0", a_perr, a_code); end
        step(8'h00);
    endtask

    task automatic test_early();
        err_clr = 1'b1;
        step(8'h01);
        err_clr = 1'b0;
        total++; if (a_sticky !== 1'b0) begin bad++; $display("FAIL early_clr got=%b exp=0", a_sticky); end
        step(8'h02);
        total++; if (a_perr !== 1'b1 || a_code !== 2'd1 || a_stb !== 1'b0 || a_lock !== 1'b0) begin bad++; $display("FAIL early_err got perr=%b code=%0d stb=%b lock=%b exp 1 1 0 0", a_perr, a_code, a_stb, a_lock); end
        step(8'h00);
        step(8'h01); step(8'h00);
        err_clr = 1'b1;
        step(8'h04);
        err_clr = 1'b0;
        total++; if (a_perr !== 1'b1 || a_sticky !== 1'b1 || a_code !== 2'd2) begin bad++; $display("FAIL clr_vs_order got perr=%b sticky=%b code=%0d exp 1 1 2", a_perr, a_sticky, a_code); end
        step(8'h00);
        step(8'h01);
        err_clr = 1'b1;
        step(8'h02);
        err_clr = 1'b0;
        total++; if (a_perr !== 1'b1 || a_sticky !== 1'b1 || a_code !== 2'd1) begin bad++; $display("FAIL clr_vs_early got perr=%b sticky=%b code=%0d exp 1 1 1", a_perr, a_sticky, a_code); end
        step(8'h00);
    endtask

    task automatic test_reset_mid();
        run_cycle();
        total++; if (a_lock !== 1'b1) begin bad++; $display("FAIL mid_prelock got=%b exp=1", a_lock); end
        step(8'h01); step(8'h00); step(8'h02); step(8'h00); step(8'h04); step(8'h00);
        #2 reset = 1'b1;
        #1;
        total++; if ({a_idx, a_stb, a_done, a_lock, a_perr, a_code, a_sticky} !== 10'd0 || a_cnt !== 16'd0) begin bad++; $display("FAIL mid_async got outs=%b cnt=%0d exp 0 0", {a_idx, a_stb, a_done, a_lock, a_perr, a_code, a_sticky}, a_cnt); end
        @(negedge clk);
        reset = 1'b0;
        step(8'h08);
        total++; if (a_stb !== 1'b0 || a_perr !== 1'b0 || a_lock !== 1'b0) begin bad++; $display("FAIL mid_stray got stb=%b perr=%b lock=%b exp 0 0 0", a_stb, a_perr, a_lock); end
        step(8'h00);
        run_cycle();
        total++; if (a_lock !== 1'b1 || a_idx !== 3'd7 || a_cnt !== 16'd1 || a_sticky !== 1'b0) begin bad++; $display("FAIL mid_relock got lock=%b idx=%0d cnt=%0d sticky=%b exp 1 7 1 0", a_lock, a_idx, a_cnt, a_sticky); end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 14; c++) begin
            run_cycle();
        end
        total++; if (b_cnt !== 4'd15 || a_cnt !== 16'd15) begin bad++; $display("FAIL wrap_pre got b=%0d a=%0d exp 15 15", b_cnt, a_cnt); end
        for (int i = 0; i < 7; i++) begin
            step(8'h01 << i);
            step(8'h00);
        end
        step(8'h80);
        total++; if (b_done !== 1'b1 || b_cnt !== 4'd0 || b_lock !== 1'b1) begin bad++; $display("FAIL wrap_zero got done=%b cnt=%0d lock=%b exp 1 0 1", b_done, b_cnt, b_lock); end
        total++; if (a_cnt !== 16'd16) begin bad++; $display("FAIL wrap_wide got=%0d exp=16", a_cnt); end
        step(8'h00);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_late();
        test_order();
        test_multi();
        test_early();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
